relogio_parametrizado: RTL and testbench

Parametrised successor of the team's hh:mm:ss counter. An internal prescaler derives the count rate from the system clock, so time advances in real seconds rather than every clock. Adds up/down (timer) counting, a configurable hour modulus, validated load, and a latched alarm. Sits between the board-level clock and the display/UI blocks.

---
 rtl/relogio_pkg.sv | 52 +++++
 rtl/relogio_parametrizado_divisor_tick.sv | 38 +++
 rtl/relogio_parametrizado.sv | 111 +++++++++++
 tb/tb_relogio_parametrizado.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
// Shared time type and field arithmetic for the parametrised clock.
// The hour field is held at 6 bits (enough for 64 hours) and truncated to H_W at the top level.
package relogio_pkg;

  localparam logic [5:0] SEG_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [5:0] horas;
    logic [5:0] minutos;
    logic [5:0] segundos;
  } tempo_t;

  function automatic tempo_t tempo_inc(tempo_t t, logic [5:0] hora_ult);
    tempo_t r;
    r = t;
    if (t.segundos == SEG_MAX) begin
      r.segundos = 6'd0;
      if (t.minutos == MIN_MAX) begin
        r.minutos = 6'd0;
        r.horas   = (t.horas == hora_ult) ? 6'd0 : t.horas + 6'd1;
      end else begin
        r.minutos = t.minutos + 6'd1;
      end
    end else begin
      r.segundos = t.segundos + 6'd1;
    end
    return r;
  endfunction

  function automatic tempo_t tempo_dec(tempo_t t, logic [5:0] hora_ult);
    tempo_t r;
    r = t;
    if (t.segundos == 6'd0) begin
      r.segundos = SEG_MAX;
      if (t.minutos == 6'd0) begin
        r.minutos = MIN_MAX;
        r.horas   = (t.horas == 6'd0) ? hora_ult : t.horas - 6'd1;
      end else begin
        r.minutos = t.minutos - 6'd1;
      end
    end else begin
      r.segundos = t.segundos - 6'd1;
    end
    return r;
  endfunction

  function automatic logic tempo_valido(tempo_t t, logic [5:0] hora_ult);
    return (t.segundos <= SEG_MAX) && (t.minutos <= MIN_MAX) && (t.horas <= hora_ult);
  endfunction

endpackage

// File: rtl/relogio_parametrizado_divisor_tick.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the wrap edge combinationally.
module divisor_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_100MHz,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] ULT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = en && (cnt_q == ULT);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = wrap;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/relogio_parametrizado.sv
// hh:mm:ss clock/timer with prescaler, up/down count, validated load and latched alarm.
module relogio_parametrizado
  import relogio_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned HORAS_MAX = 24,
  localparam int unsigned H_W      = $clog2(HORAS_MAX)
) (
  input  logic           clk_100MHz,
  input  logic           rstn,
  input  logic           pause,
  input  logic           load,
  input  logic [5:0]     load_segundos,
  input  logic [5:0]     load_minutos,
  input  logic [H_W-1:0] load_horas,
  input  logic           down,
  input  logic           alarm_en,
  input  logic           alarm_set,
  input  logic [H_W-1:0] alarm_horas,
  input  logic [5:0]     alarm_minutos,
  input  logic           alarm_clr,
  output logic [5:0]     segundos,
  output logic [5:0]     minutos,
  output logic [H_W-1:0] horas,
  output logic           tick,
  output logic           alarm,
  output logic           load_err
);

  localparam int unsigned DIV = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
  localparam logic [5:0] HORA_ULT = 6'(HORAS_MAX - 1);

  if (TICK_HZ == 0 || DIV < 1 || (CLK_HZ % TICK_HZ) != 0) begin : gen_div_check
    $fatal(1, "CLK_HZ/TICK_HZ must be an integer >= 1");
  end
  if (HORAS_MAX < 2 || HORAS_MAX > 64) begin : gen_horas_check
    $fatal(1, "HORAS_MAX must be in 2..64");
  end

  tempo_t     tempo_q, tempo_d, load_t, alarm_t;
  logic [5:0] alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
  logic       tick_q, tick_d, alarm_q, alarm_d, err_q, err_d;
  logic       advance, load_ok, aset_ok, match;

  divisor_tick #(
    .DIV(DIV)
  ) u_divisor (
    .clk_100MHz(clk_100MHz),
    .rstn      (rstn),
    .en        (!pause),
    .clr       (load_ok),
    .tick_o    (advance)
  );

  always_comb begin
    load_t  = '{horas: 6'(load_horas), minutos: load_minutos, segundos: load_segundos};
    alarm_t = '{horas: 6'(alarm_horas), minutos: alarm_minutos, segundos: 6'd0};
    load_ok = load && tempo_valido(load_t, HORA_ULT);
    aset_ok = alarm_set && tempo_valido(alarm_t, HORA_ULT);

    tempo_d = tempo_q;
    if (load_ok) begin
      tempo_d = load_t;
    end else if (advance) begin
      tempo_d = down ? tempo_dec(tempo_q, HORA_ULT) : tempo_inc(tempo_q, HORA_ULT);
    end

    tick_d = advance && !load_ok;
    err_d  = (load && !load_ok) || (alarm_set && !aset_ok);

    // Match uses the alarm time stored before this edge; loads never trigger.
    match = tick_d && alarm_en && (tempo_d == {alarm_h_q, alarm_m_q, 6'd0});

    alarm_d = alarm_q;
    if (match) begin
      alarm_d = 1'b1;
    end else if (alarm_clr || !alarm_en) begin
      alarm_d = 1'b0;
    end

    alarm_h_d = aset_ok ? alarm_t.horas : alarm_h_q;
    alarm_m_d = aset_ok ? alarm_t.minutos : alarm_m_q;
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      tempo_q   <= '0;
      alarm_h_q <= '0;
      alarm_m_q <= '0;
      tick_q    <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tempo_q   <= tempo_d;
      alarm_h_q <= alarm_h_d;
      alarm_m_q <= alarm_m_d;
      tick_q    <= tick_d;
      alarm_q   <= alarm_d;
      err_q     <= err_d;
    end
  end

  assign segundos = tempo_q.segundos;
  assign minutos  = tempo_q.minutos;
  assign horas    = tempo_q.horas[H_W-1:0];
  assign tick     = tick_q;
  assign alarm    = alarm_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_relogio_parametrizado.sv
// Scoreboard bench: a seconds-of-day reference model queues expected outputs per edge.
module tb_relogio_parametrizado;

  localparam int unsigned CLK_HZ  = 4;
  localparam int unsigned TICK_HZ = 1;
  localparam int unsigned HM      = 12;
  localparam int unsigned HW      = $clog2(HM);
  localparam int          DIV     = CLK_HZ / TICK_HZ;
  localparam int          N       = HM * 3600;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          pause = 0, load = 0, down = 0, alarm_en = 0, alarm_set = 0, alarm_clr = 0;
  logic [5:0]    load_segundos = 0, load_minutos = 0, alarm_minutos = 0;
  logic [HW-1:0] load_horas = 0, alarm_horas = 0;
  logic [5:0]    segundos, minutos;
  logic [HW-1:0] horas;
  logic          tick, alarm, load_err;

  relogio_parametrizado #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .HORAS_MAX(HM)
  ) dut (
    .clk_100MHz   (clk),
    .rstn         (rstn),
    .pause        (pause),
    .load         (load),
    .load_segundos(load_segundos),
    .load_minutos (load_minutos),
    .load_horas   (load_horas),
    .down         (down),
    .alarm_en     (alarm_en),
    .alarm_set    (alarm_set),
    .alarm_horas  (alarm_horas),
    .alarm_minutos(alarm_minutos),
    .alarm_clr    (alarm_clr),
    .segundos     (segundos),
    .minutos      (minutos),
    .horas        (horas),
    .tick         (tick),
    .alarm        (alarm),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int m;
    int h;
    bit tk;
    bit al;
    bit er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: prescaler phase, seconds since 00:00:00, alarm as minutes of day.
  int   phase = 0, secs = 0, amin = 0;
  bit   al = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input bit p, input bit ld, input int ls, input int lm, input int lh,
                       input bit dn, input bit aen, input bit aset, input int ah, input int am,
                       input bit aclr);
    int   nsec;
    bit   lok, adv, aok, tk, er;
    exp_t e;
    pause = p; load = ld; down = dn; alarm_en = aen; alarm_set = aset; alarm_clr = aclr;
    load_segundos = 6'(ls); load_minutos = 6'(lm); load_horas = HW'(lh);
    alarm_horas = HW'(ah); alarm_minutos = 6'(am);
    lok = ld && ls <= 59 && lm <= 59 && lh < HM;
    adv = !p && phase == DIV - 1;
    aok = aset && ah < HM && am <= 59;
    if (lok) begin
      nsec  = lh * 3600 + lm * 60 + ls;
      phase = 0;
    end else begin
      nsec = !adv ? secs : (dn ? (secs + N - 1) % N : (secs + 1) % N);
      if (!p) phase = (phase + 1) % DIV;
    end
    tk = adv && !lok;
    er = (ld && !lok) || (aset && !aok);
    if (tk && aen && nsec == amin * 60) al = 1;
    else if (aclr || !aen) al = 0;
    if (aok) amin = ah * 60 + am;
    secs = nsec;
    e.s = secs % 60; e.m = (secs / 60) % 60; e.h = secs / 3600;
    e.tk = tk; e.al = al; e.er = er;
    sb.push_back(e);
  endtask

  task automatic step(input bit p, input bit ld, input int ls, input int lm, input int lh,
                      input bit dn, input bit aen, input bit aset, input int ah, input int am,
                      input bit aclr);
    @(negedge clk);
    apply(p, ld, ls, lm, lh, dn, aen, aset, ah, am, aclr);
  endtask

  task automatic idle(input int n, input bit dn);
    repeat (n) step(0, 0, 0, 0, 0, dn, 1, 0, 0, 0, 0);
  endtask

  task automatic ld_time(input int h, input int m, input int s, input bit dn);
    step(0, 1, s, m, h, dn, 1, 0, 0, 0, 0);
  endtask

  // Reset lands between clock edges; outputs must clear without any clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_seg", int'(segundos), 0);
    chk("rst_min", int'(minutos), 0);
    chk("rst_hor", int'(horas), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_err", int'(load_err), 0);
    repeat (2) @(negedge clk);
    phase = 0; secs = 0; amin = 0; al = 0;
    rstn = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("segundos", int'(segundos), e.s);
        chk("minutos", int'(minutos), e.m);
        chk("horas", int'(horas), e.h);
        chk("tick", int'(tick), int'(e.tk));
        chk("alarm", int'(alarm), int'(e.al));
        chk("load_err", int'(load_err), int'(e.er));
      end
    end
  end

  initial begin : stimulus
    bit dn_r;
    do_reset();
    idle(25, 0);
    ld_time(11, 59, 59, 0);
    idle(5, 0);
    ld_time(0, 0, 0, 1);
    idle(5, 1);
    ld_time(5, 10, 20, 0);
    ld_time(12, 10, 20, 0);
    idle(1, 0);
    ld_time(5, 10, 60, 0);
    idle(2, 0);
    ld_time(11, 59, 59, 0);
    idle(2, 0);
    repeat (20) step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(8, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 13, 2, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 60, 0);
    // Alarm 01:02, load 01:01:59: fourth edge after the load advances and matches.
    step(0, 1, 59, 1, 1, 0, 1, 1, 1, 2, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    idle(1, 0);
    do_reset();
    step(0, 1, 0, 2, 1, 0, 1, 1, 1, 2, 0);
    idle(6, 0);
    ld_time(1, 1, 59, 0);
    idle(3, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    idle(2, 0);

    dn_r = 0;
    for (int i = 0; i < 3000; i++) begin
      int t, ls, lm, lh, ah, am;
      bit p, ld, aen, aset, aclr;
      if ($urandom_range(0, 39) == 0) dn_r = !dn_r;
      p    = $urandom_range(0, 7) == 0;
      ld   = $urandom_range(0, 11) == 0;
      aen  = $urandom_range(0, 29) != 0;
      aset = $urandom_range(0, 49) == 0;
      aclr = $urandom_range(0, 19) == 0;
      ah   = int'($urandom_range(0, 15));
      am   = int'($urandom_range(0, 63));
      ls   = int'($urandom_range(0, 63));
      lm   = int'($urandom_range(0, 63));
      lh   = int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        1: t = (amin * 60 + int'($urandom_range(0, 3))) % N;
        2: t = (amin * 60 + N - int'($urandom_range(1, 4))) % N;
        3: t = (N + int'($urandom_range(0, 4)) - 2) % N;
        default: t = -1;
      endcase
      if (t >= 0) begin
        ls = t % 60; lm = (t / 60) % 60; lh = t / 3600;
      end
      step(p, ld, ls, lm, lh, dn_r, aen, aset, ah, am, aclr);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
